// File: rtl/scoreboard_pkg.sv
// Shared types and constants for the scoreboard display: FSM states,
// seven-segment codes and digit-position indices.
package scoreboard_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CONV_U,
    ST_CONV_D,
    ST_CONV_B,
    ST_COMMIT
  } state_t;

  // Segment order {g,f,e,d,c,b,a}, active-high
  localparam logic [6:0] SEG_0     = 7'b0111111;
  localparam logic [6:0] SEG_1     = 7'b0000110;
  localparam logic [6:0] SEG_2     = 7'b1011011;
  localparam logic [6:0] SEG_3     = 7'b1001111;
  localparam logic [6:0] SEG_4     = 7'b1100110;
  localparam logic [6:0] SEG_5     = 7'b1101101;
  localparam logic [6:0] SEG_6     = 7'b1111101;
  localparam logic [6:0] SEG_7     = 7'b0000111;
  localparam logic [6:0] SEG_8     = 7'b1111111;
  localparam logic [6:0] SEG_9     = 7'b1101111;
  localparam logic [6:0] SEG_BLANK = 7'b0000000;

  localparam logic [1:0] DIG_3 = 2'd3;
  localparam logic [1:0] DIG_2 = 2'd2;
  localparam logic [1:0] DIG_1 = 2'd1;
  localparam logic [1:0] DIG_0 = 2'd0;

  function automatic logic [6:0] seg_code(input logic [3:0] bcd);
    logic [6:0] s;
    case (bcd)
      4'd0:    s = SEG_0;
      4'd1:    s = SEG_1;
      4'd2:    s = SEG_2;
      4'd3:    s = SEG_3;
      4'd4:    s = SEG_4;
      4'd5:    s = SEG_5;
      4'd6:    s = SEG_6;
      4'd7:    s = SEG_7;
      4'd8:    s = SEG_8;
      4'd9:    s = SEG_9;
      default: s = SEG_BLANK;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// Iterative double-dabble: start loads at edge 0, ten shift edges follow,
// and done is high for the one cycle that is sampled at edge 11.
module bin2bcd_seq
  import scoreboard_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic [9:0]  bin,
  input  logic        start,
  output logic        busy,
  output logic        done,
  output logic [15:0] bcd
);

  // {bcd[15:0], binary[9:0]} working register
  logic [25:0] work;
  logic [3:0]  cnt;

  function automatic logic [25:0] dabble(input logic [25:0] w);
    logic [25:0] a;
    a = w;
    for (int i = 0; i < 4; i++) begin
      if (a[10+4*i +: 4] >= 4'd5)
        a[10+4*i +: 4] = a[10+4*i +: 4] + 4'd3;
    end
    return {a[24:0], 1'b0};
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      work <= '0;
      cnt  <= '0;
      busy <= 1'b0;
      done <= 1'b0;
    end else if (start) begin
      work <= {16'd0, bin};
      cnt  <= '0;
      busy <= 1'b1;
      done <= 1'b0;
    end else if (busy) begin
      work <= dabble(work);
      cnt  <= cnt + 4'd1;
      if (cnt == 4'd9) begin
        busy <= 1'b0;
        done <= 1'b1;
      end
    end else begin
      done <= 1'b0;
    end
  end

  assign bcd = work[25:10];

endmodule

// File: rtl/scoreboard_display.sv
// Converts the blackjack totals and balance to BCD with one shared converter
// and scans them onto a 4-digit multiplexed seven-segment display.
module scoreboard_display
  import scoreboard_pkg::*;
#(
  parameter int REFRESH_DIV = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [5:0] user_total,
  input  logic [5:0] dealer_total,
  input  logic [9:0] balance,
  input  logic       page_sel,
  input  logic       blank,
  output logic [6:0] seg,
  output logic       dp,
  output logic [3:0] an,
  output logic       conv_busy
);

  localparam int PW = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [PW-1:0] LAST = PW'(REFRESH_DIV - 1);

  state_t      state, state_nxt;
  logic [5:0]  snap_u, snap_d;
  logic [9:0]  snap_b;
  logic [7:0]  pend_u, pend_d, disp_u, disp_d;
  logic [15:0] pend_b, disp_b;

  logic        cv_start, cv_busy, cv_done;
  logic [9:0]  cv_bin;
  logic [15:0] cv_bcd;
  logic        capture, store_u, store_d, store_b, commit;

  bin2bcd_seq u_bcd (
    .clk   (clk),
    .rst_n (rst_n),
    .bin   (cv_bin),
    .start (cv_start),
    .busy  (cv_busy),
    .done  (cv_done),
    .bcd   (cv_bcd)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  // Later conversions use the snapshots so all three values belong to one frame
  always_comb begin
    state_nxt = state;
    cv_start  = 1'b0;
    cv_bin    = 10'd0;
    capture   = 1'b0;
    store_u   = 1'b0;
    store_d   = 1'b0;
    store_b   = 1'b0;
    commit    = 1'b0;
    case (state)
      ST_IDLE: begin
        if (!cv_busy && (user_total != snap_u || dealer_total != snap_d ||
                         balance != snap_b)) begin
          capture   = 1'b1;
          cv_start  = 1'b1;
          cv_bin    = {4'd0, user_total};
          state_nxt = ST_CONV_U;
        end
      end
      ST_CONV_U: begin
        if (cv_done) begin
          store_u   = 1'b1;
          cv_start  = 1'b1;
          cv_bin    = {4'd0, snap_d};
          state_nxt = ST_CONV_D;
        end
      end
      ST_CONV_D: begin
        if (cv_done) begin
          store_d   = 1'b1;
          cv_start  = 1'b1;
          cv_bin    = snap_b;
          state_nxt = ST_CONV_B;
        end
      end
      ST_CONV_B: begin
        if (cv_done) begin
          store_b   = 1'b1;
          state_nxt = ST_COMMIT;
        end
      end
      ST_COMMIT: begin
        commit    = 1'b1;
        state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  assign conv_busy = (state != ST_IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      snap_u <= '0;
      snap_d <= '0;
      snap_b <= '0;
      pend_u <= '0;
      pend_d <= '0;
      pend_b <= '0;
      disp_u <= '0;
      disp_d <= '0;
      disp_b <= '0;
    end else begin
      if (capture) begin
        snap_u <= user_total;
        snap_d <= dealer_total;
        snap_b <= balance;
      end
      if (store_u) pend_u <= cv_bcd[7:0];
      if (store_d) pend_d <= cv_bcd[7:0];
      if (store_b) pend_b <= cv_bcd;
      if (commit) begin
        disp_u <= pend_u;
        disp_d <= pend_d;
        disp_b <= pend_b;
      end
    end
  end

  logic [PW-1:0] pre_cnt;
  logic [1:0]    idx, idx_nxt;
  logic          page_q, page_nxt, wrap;
  logic [6:0]    seg_nxt;
  logic          dp_nxt;
  logic [3:0]    an_nxt;

  assign wrap     = (pre_cnt == LAST);
  assign idx_nxt  = wrap ? idx - 2'd1 : idx;
  assign page_nxt = (wrap && idx == DIG_0) ? page_sel : page_q;
  assign an_nxt   = blank ? 4'b0000 : (4'b0001 << idx_nxt);

  always_comb begin
    seg_nxt = SEG_BLANK;
    dp_nxt  = 1'b0;
    if (!page_nxt) begin
      case (idx_nxt)
        DIG_3: seg_nxt = (disp_u[7:4] == 4'd0) ? SEG_BLANK : seg_code(disp_u[7:4]);
        DIG_2: begin
          seg_nxt = seg_code(disp_u[3:0]);
          dp_nxt  = 1'b1;
        end
        DIG_1: seg_nxt = (disp_d[7:4] == 4'd0) ? SEG_BLANK : seg_code(disp_d[7:4]);
        default: seg_nxt = seg_code(disp_d[3:0]);
      endcase
    end else begin
      case (idx_nxt)
        DIG_3: seg_nxt = (disp_b[15:12] == 4'd0) ? SEG_BLANK : seg_code(disp_b[15:12]);
        DIG_2: seg_nxt = (disp_b[15:8] == 8'd0) ? SEG_BLANK : seg_code(disp_b[11:8]);
        DIG_1: seg_nxt = (disp_b[15:4] == 12'd0) ? SEG_BLANK : seg_code(disp_b[7:4]);
        default: seg_nxt = seg_code(disp_b[3:0]);
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pre_cnt <= '0;
      idx     <= DIG_3;
      page_q  <= 1'b0;
      seg     <= SEG_BLANK;
      dp      <= 1'b0;
      an      <= 4'b0000;
    end else begin
      pre_cnt <= wrap ? '0 : pre_cnt + PW'(1);
      idx     <= idx_nxt;
      page_q  <= page_nxt;
      seg     <= seg_nxt;
      dp      <= dp_nxt;
      an      <= an_nxt;
    end
  end

endmodule

// File: tb/tb_scoreboard_display.sv
// Randomised self-checking bench for scoreboard_display with a decimal-arithmetic
// reference model of the scan, page latch and commit timing.
module tb_scoreboard_display;

  localparam int DIV = 4;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [5:0] user_total, dealer_total;
  logic [9:0] balance;
  logic       page_sel, blank;
  logic [6:0] seg;
  logic       dp;
  logic [3:0] an;
  logic       conv_busy;

  int n_chk = 0;
  int n_err = 0;

  // model state
  int   k;
  logic pg;
  int   cu, cd, cb;

  scoreboard_display #(.REFRESH_DIV(DIV)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .user_total   (user_total),
    .dealer_total (dealer_total),
    .balance      (balance),
    .page_sel     (page_sel),
    .blank        (blank),
    .seg          (seg),
    .dp           (dp),
    .an           (an),
    .conv_busy    (conv_busy)
  );

  always #5 clk = ~clk;

  // k = number of active edges since reset release; the page is sampled
  // on every edge that takes the digit index from 0 back to 3
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      k  <= 0;
      pg <= 1'b0;
    end else begin
      k <= k + 1;
      if (((k + 1) % DIV == 0) && (((k + 1) / DIV) % 4 == 0))
        pg <= page_sel;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached, got running expected finished");
    $fatal(1);
  end

  task automatic chk(input string tag, input int got, input int exp);
    n_chk++;
    if (got != exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [6:0] segs(input int v);
    case (v)
      0: return 7'b0111111;
      1: return 7'b0000110;
      2: return 7'b1011011;
      3: return 7'b1001111;
      4: return 7'b1100110;
      5: return 7'b1101101;
      6: return 7'b1111101;
      7: return 7'b0000111;
      8: return 7'b1111111;
      default: return 7'b1101111;
    endcase
  endfunction

  task automatic exp_digit(input int pos, input logic page, input int u, input int d,
                           input int b, output logic [6:0] s, output logic p);
    int v;
    bit show;
    p = 1'b0;
    v = 0;
    show = 1'b1;
    if (!page) begin
      case (pos)
        3: begin v = u / 10; show = (v != 0); end
        2: begin v = u % 10; p = 1'b1; end
        1: begin v = d / 10; show = (v != 0); end
        default: v = d % 10;
      endcase
    end else begin
      case (pos)
        3: begin v = b / 1000;       show = (b >= 1000); end
        2: begin v = (b / 100) % 10; show = (b >= 100);  end
        1: begin v = (b / 10) % 10;  show = (b >= 10);   end
        default: v = b % 10;
      endcase
    end
    s = show ? segs(v) : 7'b0000000;
  endtask

  task automatic check_frame(input int n);
    logic [6:0] es;
    logic       ep;
    int         ix;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      ix = 3 - ((k / DIV) % 4);
      exp_digit(ix, pg, cu, cd, cb, es, ep);
      chk("an", an, blank ? 0 : (1 << ix));
      if (!blank) begin
        chk("seg", seg, es);
        chk("dp", dp, ep);
      end
    end
  endtask

  // Drive new inputs while idle and check the 34-edge commit latency
  task automatic apply(input int u, input int d, input int b);
    @(negedge clk);
    user_total   = 6'(u);
    dealer_total = 6'(d);
    balance      = 10'(b);
    @(negedge clk);
    chk("busy_rise", conv_busy, 1);
    repeat (33) @(negedge clk);
    chk("busy_hold", conv_busy, 1);
    @(negedge clk);
    chk("busy_fall", conv_busy, 0);
    cu = u;
    cd = d;
    cb = b;
    check_frame(8 * DIV);
  endtask

  initial begin
    int u, d, b;
    rst_n        = 1'b0;
    user_total   = 6'd7;
    dealer_total = 6'd9;
    balance      = 10'd500;
    page_sel     = 1'b0;
    blank        = 1'b0;
    cu = 0; cd = 0; cb = 0;

    // reset state with nonzero inputs
    repeat (3) @(negedge clk);
    chk("rst_an", an, 0);
    chk("rst_seg", seg, 0);
    chk("rst_dp", dp, 0);
    chk("rst_busy", conv_busy, 0);

    user_total   = 6'd0;
    dealer_total = 6'd0;
    balance      = 10'd100;
    page_sel     = 1'b1;
    rst_n        = 1'b1;
    @(negedge clk);
    chk("busy_rise", conv_busy, 1);
    repeat (33) @(negedge clk);
    chk("busy_hold", conv_busy, 1);
    @(negedge clk);
    chk("busy_fall", conv_busy, 0);
    cb = 100;
    check_frame(8 * DIV);

    // totals page patterns and leading blanks
    page_sel = 1'b0;
    apply(21, 17, 100);
    apply(5, 10, 100);

    // balance page
    page_sel = 1'b1;
    apply(5, 10, 1023);
    apply(5, 10, 50);

    // page change mid-frame, at digit 2
    while (3 - ((k / DIV) % 4) != 2) @(negedge clk);
    page_sel = 1'b0;
    check_frame(8 * DIV);
    page_sel = 1'b1;
    check_frame(6 * DIV);

    // blank keeps the scan running with all enables off
    blank = 1'b1;
    check_frame(2 * DIV);
    blank = 1'b0;
    check_frame(4 * DIV);

    // change during a conversion: first commit keeps the snapshot, then retrigger
    @(negedge clk);
    balance = 10'd100;
    @(negedge clk);
    chk("mid_busy_rise", conv_busy, 1);
    repeat (9) @(negedge clk);
    balance = 10'd250;
    repeat (24) @(negedge clk);
    chk("mid_busy_hold", conv_busy, 1);
    @(negedge clk);
    chk("mid_commit1", conv_busy, 0);
    cb = 100;
    @(negedge clk);
    chk("mid_retrigger", conv_busy, 1);
    check_frame(24);
    repeat (9) @(negedge clk);
    chk("mid_busy_hold2", conv_busy, 1);
    @(negedge clk);
    chk("mid_commit2", conv_busy, 0);
    cb = 250;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("mid_idle", conv_busy, 0);
    end
    check_frame(8 * DIV);

    // randomised transactions
    for (int it = 0; it < 6; it++) begin
      u = $urandom_range(0, 63);
      d = $urandom_range(0, 63);
      b = $urandom_range(0, 1023);
      if (u == cu && d == cd && b == cb) b = (b + 1) % 1024;
      page_sel = 1'($urandom_range(0, 1));
      apply(u, d, b);
    end

    // reset in the middle of a conversion aborts without a commit
    @(negedge clk);
    user_total   = 6'd33;
    dealer_total = 6'd44;
    balance      = 10'd999;
    repeat (20) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("abort_an", an, 0);
    chk("abort_seg", seg, 0);
    chk("abort_dp", dp, 0);
    chk("abort_busy", conv_busy, 0);
    @(negedge clk);
    rst_n = 1'b1;
    cu = 0; cd = 0; cb = 0;
    @(negedge clk);
    chk("abort_busy_rise", conv_busy, 1);
    check_frame(30);
    repeat (3) @(negedge clk);
    chk("abort_busy_hold", conv_busy, 1);
    @(negedge clk);
    chk("abort_busy_fall", conv_busy, 0);
    cu = 33; cd = 44; cb = 999;
    check_frame(8 * DIV);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
